// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide engine.
// Takes one operation through a valid/ready handshake, prepares the operands
// (sign capture and absolute values), runs N = XLEN/BITS_PER_CYCLE shift-add or
// restoring shift-subtract steps on a 2*XLEN accumulator, then holds the result
// until it is consumed.
// Ports:
//   clk, reset (async, active-low)
//   op_valid/op_ready       request handshake (op_ready high only in IDLE)
//   op_func[2:0]            RV32M funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   operand_a/operand_b     rs1 / rs2 values
//   flush                   synchronous abort back to IDLE
//   busy                    high in PREP, CALC, DONE
//   result_valid/ready      result handshake, result held stable while valid
//   result                  selected result word (kept after consumption)
module mul_div_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_func,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          func_q, func_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;     // |multiplicand| or |divisor|
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_q, neg_d;       // negate product / quotient
  logic                neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                op_ready_q, op_ready_d;
  logic                busy_q, busy_d;
  logic                result_valid_q, result_valid_d;

  // Combinational helpers
  logic                is_div;
  logic                sa, sb;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                div_by_zero, div_ovf;
  logic [2*XLEN-1:0]   acc_step;
  logic [XLEN:0]       sum;
  logic [XLEN:0]       rem_ext;
  logic [XLEN-1:0]     low;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quot, rem;
  logic [XLEN-1:0]     final_res;

  always_comb begin
    is_div = func_q[2];
    // Signed operand flags: MULH/MULHSU/DIV/REM treat a as signed,
    // MULH/DIV/REM treat b as signed. MUL's low word is sign-agnostic.
    sa = a_q[XLEN-1] & ((func_q == 3'd1) | (func_q == 3'd2) |
                        (func_q == 3'd4) | (func_q == 3'd6));
    sb = b_q[XLEN-1] & ((func_q == 3'd1) | (func_q == 3'd4) | (func_q == 3'd6));
    abs_a = sa ? ('0 - a_q) : a_q;
    abs_b = sb ? ('0 - b_q) : b_q;
    div_by_zero = (b_q == '0);
    div_ovf = ((func_q == 3'd4) | (func_q == 3'd6)) &&
              (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

    // BITS_PER_CYCLE unrolled iteration steps on the accumulator.
    acc_step = acc_q;
    sum      = '0;
    rem_ext  = '0;
    low      = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        // Restoring divide: shift {rem,dividend} left, subtract if it fits.
        rem_ext = {acc_step[2*XLEN-1:XLEN], acc_step[XLEN-1]};
        low     = {acc_step[XLEN-2:0], 1'b0};
        if (rem_ext >= {1'b0, opnd_q}) begin
          rem_ext = rem_ext - {1'b0, opnd_q};
          low[0]  = 1'b1;
        end
        acc_step = {rem_ext[XLEN-1:0], low};
      end else begin
        // Shift-add multiply: multiplier in the low half, consumed LSB first.
        sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} +
                   (acc_step[0] ? {1'b0, opnd_q} : '0);
        acc_step = {sum, acc_step[XLEN-1:1]};
      end
    end

    prod = neg_q ? ('0 - acc_step) : acc_step;
    quot = acc_step[XLEN-1:0];
    rem  = acc_step[2*XLEN-1:XLEN];
    case (func_q)
      3'd0:          final_res = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          final_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:    final_res = neg_q ? ('0 - quot) : quot;
      default:       final_res = neg_rem_q ? ('0 - rem) : rem;
    endcase

    state_d   = state_q;
    func_d    = func_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid) begin
            func_d  = op_func;
            a_d     = operand_a;
            b_d     = operand_b;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
          cnt_d     = CW'(N);
          if (is_div && div_by_zero) begin
            result_d = func_q[1] ? a_q : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = func_q[1] ? '0 : a_q;
            state_d  = S_DONE;
          end else begin
            acc_d   = is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
            opnd_d  = is_div ? abs_b : abs_a;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = final_res;
            state_d  = S_DONE;
          end
        end
        default: begin
          if (result_ready) state_d = S_IDLE;
        end
      endcase
    end

    // Status outputs are registered from the next state.
    op_ready_d     = (state_d == S_IDLE);
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      func_q         <= '0;
      a_q            <= '0;
      b_q            <= '0;
      opnd_q         <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      neg_q          <= 1'b0;
      neg_rem_q      <= 1'b0;
      result_q       <= '0;
      op_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      func_q         <= func_d;
      a_q            <= a_d;
      b_q            <= b_d;
      opnd_q         <= opnd_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      neg_q          <= neg_d;
      neg_rem_q      <= neg_rem_d;
      result_q       <= result_d;
      op_ready_q     <= op_ready_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign op_ready     = op_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed RV32M vectors checked against an
// arithmetic reference model, with hand-computed literals pinning the model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_func = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        flush = 1'b0;
  logic        busy;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_res = 32'd0;

  always #5 clk = ~clk;

  mul_div_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_func(op_func), .operand_a(operand_a), .operand_b(operand_b),
    .flush(flush), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result(result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Compare process: whenever a result is presented it must match the model.
  always @(posedge clk) begin
    #3;
    if (reset && result_valid) begin
      check("cmp_result", {32'd0, result}, {32'd0, exp_res});
      check("cmp_op_ready_in_done", {63'd0, op_ready}, 64'd0);
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    exp_res   = model(f, a, b);
    op_func   = f;
    operand_a = a;
    operand_b = b;
    op_valid  = 1'b1;
    @(posedge clk);
    #1;
    op_valid  = 1'b0;
    // Scramble inputs to prove the operands were latched.
    operand_a = ~a;
    operand_b = 32'd0;
    op_func   = ~f;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit, input int lat,
                        input int hold);
    int k;
    check({name, "_model"}, {32'd0, model(f, a, b)}, {32'd0, lit});
    check({name, "_op_ready_before"}, {63'd0, op_ready}, 64'd1);
    issue(f, a, b);
    check({name, "_busy_after_accept"}, {63'd0, busy}, 64'd1);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!result_valid && k < 100);
    check({name, "_latency"}, 64'(k), 64'(lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      op_valid  = 1'b1;
      op_func   = 3'd5;
      operand_a = 32'd9;
      operand_b = 32'd3;
      @(posedge clk);
      #1;
      check({name, "_hold_valid"}, {63'd0, result_valid}, 64'd1);
      check({name, "_hold_result"}, {32'd0, result}, {32'd0, lit});
      check({name, "_hold_op_ready"}, {63'd0, op_ready}, 64'd0);
    end
    @(negedge clk);
    op_valid     = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    check({name, "_valid_cleared"}, {63'd0, result_valid}, 64'd0);
    check({name, "_idle_ready"}, {63'd0, op_ready}, 64'd1);
    check({name, "_result_kept"}, {32'd0, result}, {32'd0, lit});
    if (hold > 0) begin
      @(posedge clk);
      #1;
      check({name, "_held_op_not_queued"}, {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    // Reset state
    #12;
    check("reset_op_ready", {63'd0, op_ready}, 64'd1);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_result_valid", {63'd0, result_valid}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("mul_7_neg3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op("mulh_min_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op("mulhu_ones",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op("mulhsu_ones",   3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op("mulh_neg1_2",   3'd1, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("mul_shift",     3'd0, 32'h1234_5678,  32'h10,        32'h2345_6780, 33, 0);
    run_op("div_neg7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 0);
    run_op("rem_neg7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 0);
    run_op("div_neg7_neg2", 3'd4, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         33, 0);
    run_op("rem_7_neg2",    3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33, 0);
    run_op("divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14,        33, 0);
    run_op("remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         33, 0);
    run_op("divu_max_1",    3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33, 0);
    run_op("divu_5_0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("remu_5_0",      3'd7, 32'd5,          32'd0,         32'd5,         1,  0);
    run_op("div_5_0",       3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
    run_op("rem_neg5_0",    3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1,  0);
    run_op("div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
    run_op("rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0);
    // Back-pressure: result held 10 cycles while a new request is offered
    run_op("hold_mul",      3'd0, 32'd1000,       32'd1000,      32'd1_000_000, 33, 10);

    // Asynchronous reset mid-CALC
    issue(3'd0, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_result_valid", {63'd0, result_valid}, 64'd0);
    check("async_rst_op_ready", {63'd0, op_ready}, 64'd1);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Flush in CALC
    issue(3'd5, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_calc_op_ready", {63'd0, op_ready}, 64'd1);
    check("flush_calc_busy", {63'd0, busy}, 64'd0);
    k = 0;
    while (!result_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("flush_calc_no_result", {63'd0, result_valid}, 64'd0);

    // Flush in IDLE beats op_valid
    @(negedge clk);
    op_func   = 3'd0;
    operand_a = 32'd2;
    operand_b = 32'd2;
    op_valid  = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle_not_accepted", {63'd0, busy}, 64'd0);

    // Flush in DONE beats result_ready
    issue(3'd5, 32'd5, 32'd0);
    @(posedge clk);
    #1;
    check("flush_done_reached", {63'd0, result_valid}, 64'd1);
    @(negedge clk);
    flush        = 1'b1;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    result_ready = 1'b0;
    check("flush_done_valid", {63'd0, result_valid}, 64'd0);
    check("flush_done_op_ready", {63'd0, op_ready}, 64'd1);

    run_op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
